// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the instruction/data memory arbiter:
//   - port identifiers used in read tags and in the round-robin history
//   - the read-tag record carried alongside each outstanding read
//   - default address/data widths
// The optional round-robin mode is selected with the MEM_ARB_RR_EN macro in
// mem_arbiter.sv; nothing in this package depends on it.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // One entry per issued access; valid is set only for reads.
    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

    localparam rd_tag_t TAG_NONE = '{valid: 1'b0, port: 1'b0};

endpackage

// File: rtl/rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// rd_tag_pipe
// RD_LAT-stage shift register of read tags. The tag pushed in the issue cycle
// appears on o_tag exactly RD_LAT cycles later, aligned with the memory's
// read data. An asynchronous reset empties the pipe, discarding in-flight
// reads.
// Ports:
//   clk    in   clock
//   reset  in   asynchronous reset, active-high
//   i_tag  in   tag of the access issued this cycle
//   o_tag  out  tag of the access whose read data is on the memory bus now
// -----------------------------------------------------------------------------
module rd_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    clk,
    input  logic    reset,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t r_stage [RD_LAT];

    // Advance every tag one stage per cycle; reset drops everything in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                r_stage[k] <= TAG_NONE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int k = 1; k < RD_LAT; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign o_tag = r_stage[RD_LAT-1];

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port pipelined memory between the CPU fetch port and the
// CPU data port. At most one request is granted per cycle; the winner drives
// the memory directly in its grant cycle. Reads are tagged with their port and
// the returning data is routed back RD_LAT cycles later, in issue order.
//
// Arbitration:
//   default           data port wins ties, unless fetch has been refused
//                     MAX_WAIT consecutive cycles, then fetch wins
//   MEM_ARB_RR_EN     round robin: on a tie the port that did not win the
//                     previous grant wins (fetch first after reset)
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   i_req/i_addr                    fetch read request
//   i_gnt, i_rvalid, i_rdata        fetch grant and read return
//   d_req/d_we/d_addr/d_wdata       data request
//   d_gnt, d_rvalid, d_rdata        data grant and read return
//   mem_en/mem_we/mem_addr/mem_wdata   memory command (zeros when idle)
//   mem_rdata                       memory read data, RD_LAT cycles after issue
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait_cnt;
    logic              w_i_wins;
    logic              w_i_gnt;
    logic              w_d_gnt;
    rd_tag_t           w_push_tag;
    rd_tag_t           w_ret_tag;

`ifdef MEM_ARB_RR_EN
    logic r_last_winner;

    // Tie-break: the port that did not win most recently goes next
    always_comb begin
        if (d_req) begin
            w_i_wins = (r_last_winner == PORT_D);
        end else begin
            w_i_wins = 1'b1;
        end
    end

    // Track the most recent winner; starting at data lets fetch go first
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_winner <= PORT_D;
        end else if (w_i_gnt) begin
            r_last_winner <= PORT_I;
        end else if (w_d_gnt) begin
            r_last_winner <= PORT_D;
        end else begin
            r_last_winner <= r_last_winner;
        end
    end

    // The starvation counter has no role in round-robin mode
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end
    end
`else
    // Tie-break: data wins unless fetch has waited the maximum allowed
    always_comb begin
        if (d_req) begin
            w_i_wins = (r_wait_cnt == WAIT_LIMIT);
        end else begin
            w_i_wins = 1'b1;
        end
    end

    // Count consecutive refused fetch cycles, saturating at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (w_i_gnt) begin
            r_wait_cnt <= {WAIT_W{1'b0}};
        end else if (i_req && (r_wait_cnt != WAIT_LIMIT)) begin
            r_wait_cnt <= r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
            r_wait_cnt <= r_wait_cnt;
        end
    end
`endif

    // Grant selection; nothing is granted while reset is held
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (reset) begin
            w_i_gnt = 1'b0;
            w_d_gnt = 1'b0;
        end else if (i_req && w_i_wins) begin
            w_i_gnt = 1'b1;
        end else if (d_req) begin
            w_d_gnt = 1'b1;
        end else begin
            w_i_gnt = 1'b0;
            w_d_gnt = 1'b0;
        end
    end

    // Winner drives the memory in its grant cycle; idle bus is all zeros
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (w_i_gnt) begin
            mem_en   = 1'b1;
            mem_addr = i_addr;
        end else if (w_d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else begin
            mem_en = 1'b0;
        end
    end

    // Only reads produce a return, so writes push an invalid tag
    always_comb begin
        w_push_tag.valid = w_i_gnt | (w_d_gnt & ~d_we);
        w_push_tag.port  = w_d_gnt ? PORT_D : PORT_I;
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk   (clk),
        .reset (reset),
        .i_tag (w_push_tag),
        .o_tag (w_ret_tag)
    );

    assign i_gnt    = w_i_gnt;
    assign d_gnt    = w_d_gnt;
    assign i_rvalid = w_ret_tag.valid & (w_ret_tag.port == PORT_I);
    assign d_rvalid = w_ret_tag.valid & (w_ret_tag.port == PORT_D);
    assign i_rdata  = i_rvalid ? mem_rdata : {DATA_W{1'b0}};
    assign d_rdata  = d_rvalid ? mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Two arbiters (read latency 1 and 3) share one stimulus stream. Each has its
// own bench-side memory that reacts to the arbiter's memory outputs. A
// behavioural model (grant rule + queue of expected returns) predicts every
// output each cycle; directed phases add literal expectations.
// Honours MEM_ARB_RR_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int MAXW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;

    logic [1:0]       o_ig, o_dg, o_iv, o_dv, o_en, o_we;
    logic [1:0][31:0] o_ir, o_dr, o_ad, o_wd;
    logic [31:0]      rdat0 = 32'h0;
    logic [31:0]      rdat1 = 32'h0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .MAX_WAIT(MAXW)) u_dut0 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(o_ig[0]), .i_rvalid(o_iv[0]), .i_rdata(o_ir[0]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(o_dg[0]), .d_rvalid(o_dv[0]), .d_rdata(o_dr[0]),
        .mem_en(o_en[0]), .mem_we(o_we[0]), .mem_addr(o_ad[0]), .mem_wdata(o_wd[0]),
        .mem_rdata(rdat0)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .MAX_WAIT(MAXW)) u_dut1 (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(o_ig[1]), .i_rvalid(o_iv[1]), .i_rdata(o_ir[1]),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(o_dg[1]), .d_rvalid(o_dv[1]), .d_rdata(o_dr[1]),
        .mem_en(o_en[1]), .mem_we(o_we[1]), .mem_addr(o_ad[1]), .mem_wdata(o_wd[1]),
        .mem_rdata(rdat1)
    );

    typedef struct {
        int          due;
        logic        port;
        logic [31:0] data;
    } ret_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          refused = 0;
    logic        last_d = 1'b1;
    logic        g_i = 1'b0;
    logic        g_d = 1'b0;
    ret_t        rq [2][$];
    logic [31:0] mem [2][16];
    logic [31:0] refm [16];
    logic [31:0] rp1 [3];

    logic [1:0]       s_ig, s_dg, s_iv, s_dv, s_en, s_we;
    logic [1:0][31:0] s_ir, s_dr, s_ad, s_wd;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", name, inst, cyc, act, exp);
        end
    endtask

    task automatic preset(input int idx, input logic [31:0] val);
        mem[0][idx] = val;
        mem[1][idx] = val;
        refm[idx]   = val;
    endtask

    // One clock cycle: predict, compare at negedge, then advance memories and model.
    task automatic tick();
        logic        eg_i, eg_d, e_en, e_we, e_iv, e_dv;
        logic [31:0] e_addr, e_wd, e_ir, e_dr, rv0, rv1;
        ret_t        r;
        eg_i = 1'b0;
        eg_d = 1'b0;
        if (!reset) begin
`ifdef MEM_ARB_RR_EN
            eg_i = i_req && (!d_req || last_d);
`else
            eg_i = i_req && (!d_req || refused >= MAXW);
`endif
            eg_d = d_req && !eg_i;
        end
        e_en   = eg_i || eg_d;
        e_we   = eg_d && d_we;
        e_addr = eg_i ? i_addr : (eg_d ? d_addr : 32'h0);
        e_wd   = eg_d ? d_wdata : 32'h0;
        if (reset) begin
            rq[0].delete();
            rq[1].delete();
        end

        @(negedge clk);
        s_ig = o_ig; s_dg = o_dg; s_iv = o_iv; s_dv = o_dv; s_en = o_en; s_we = o_we;
        s_ir = o_ir; s_dr = o_dr; s_ad = o_ad; s_wd = o_wd;
        for (int k = 0; k < 2; k++) begin
            e_iv = 1'b0; e_dv = 1'b0; e_ir = 32'h0; e_dr = 32'h0;
            if (rq[k].size() > 0 && rq[k][0].due == cyc) begin
                r = rq[k].pop_front();
                if (r.port) begin
                    e_dv = 1'b1; e_dr = r.data;
                end else begin
                    e_iv = 1'b1; e_ir = r.data;
                end
            end
            chk("i_gnt", k, {31'h0, s_ig[k]}, {31'h0, eg_i});
            chk("d_gnt", k, {31'h0, s_dg[k]}, {31'h0, eg_d});
            chk("mem_en", k, {31'h0, s_en[k]}, {31'h0, e_en});
            chk("mem_we", k, {31'h0, s_we[k]}, {31'h0, e_we});
            chk("mem_addr", k, s_ad[k], e_addr);
            chk("mem_wdata", k, s_wd[k], e_wd);
            chk("i_rvalid", k, {31'h0, s_iv[k]}, {31'h0, e_iv});
            chk("i_rdata", k, s_ir[k], e_ir);
            chk("d_rvalid", k, {31'h0, s_dv[k]}, {31'h0, e_dv});
            chk("d_rdata", k, s_dr[k], e_dr);
        end

        @(posedge clk);
        #1;
        // Bench memories respond to what each arbiter actually drove.
        rv0 = $urandom;
        rv1 = $urandom;
        if (s_en[0] && !s_we[0]) rv0 = mem[0][s_ad[0][5:2]];
        if (s_en[0] && s_we[0]) mem[0][s_ad[0][5:2]] = s_wd[0];
        if (s_en[1] && !s_we[1]) rv1 = mem[1][s_ad[1][5:2]];
        if (s_en[1] && s_we[1]) mem[1][s_ad[1][5:2]] = s_wd[1];
        rdat0  = rv0;
        rp1[2] = rp1[1];
        rp1[1] = rp1[0];
        rp1[0] = rv1;
        rdat1  = rp1[2];

        // Reference model advance.
        if (eg_d && d_we) refm[d_addr[5:2]] = d_wdata;
        if (eg_i || (eg_d && !d_we)) begin
            r.port = eg_d;
            r.data = eg_i ? refm[i_addr[5:2]] : refm[d_addr[5:2]];
            r.due  = cyc + 1;
            rq[0].push_back(r);
            r.due  = cyc + 3;
            rq[1].push_back(r);
        end
        if (reset || eg_i) refused = 0;
        else if (i_req && refused < MAXW) refused++;
        if (reset) last_d = 1'b1;
        else if (eg_i) last_d = 1'b0;
        else if (eg_d) last_d = 1'b1;
        g_i = eg_i;
        g_d = eg_d;
        cyc++;
    endtask

    initial begin
        string       pat;
        string       exp_pat;
        logic        seen;
        for (int j = 0; j < 16; j++) preset(j, $urandom);
        for (int j = 0; j < 3; j++) rp1[j] = 32'h0;

        // Reset, then idle
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("idle_gnt", 0, {30'h0, s_ig[0], s_dg[0]}, 32'h0);
        chk("idle_en", 0, {30'h0, s_en}, 32'h0);
        chk("idle_rvalid", 1, {28'h0, s_iv, s_dv}, 32'h0);

        // Fetch read of 0x10
        preset(4, 32'hDEADBEEF);
        i_req = 1'b1; i_addr = 32'h10;
        tick();
        chk("fetch_gnt", 0, {31'h0, s_ig[0]}, 32'h1);
        i_req = 1'b0;
        tick();
        chk("fetch_rvalid", 0, {31'h0, s_iv[0]}, 32'h1);
        chk("fetch_rdata", 0, s_ir[0], 32'hDEADBEEF);
        chk("fetch_no_drv", 0, {31'h0, s_dv[0]}, 32'h0);

        // Data write then read back of 0x40
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
        tick();
        chk("wr_gnt", 0, {31'h0, s_dg[0]}, 32'h1);
        chk("wr_we", 0, {31'h0, s_we[0]}, 32'h1);
        chk("wr_addr", 0, s_ad[0], 32'h40);
        chk("wr_wdata", 0, s_wd[0], 32'h12345678);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        chk("wr_no_rvalid", 0, {31'h0, s_dv[0]}, 32'h0);
        d_req = 1'b1; d_wdata = 32'h0;
        tick();
        d_req = 1'b0;
        tick();
        chk("rd_rvalid", 0, {31'h0, s_dv[0]}, 32'h1);
        chk("rd_rdata", 0, s_dr[0], 32'h12345678);
        for (int j = 0; j < 4; j++) tick();

        // Both ports requesting every cycle, fresh from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        i_req = 1'b1; i_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        pat = "";
        for (int j = 0; j < 10; j++) begin
            tick();
            pat = {pat, s_ig[0] ? "I" : (s_dg[0] ? "D" : "-")};
        end
`ifdef MEM_ARB_RR_EN
        exp_pat = "IDIDIDIDID";
`else
        exp_pat = "DDDDIDDDDI";
`endif
        checks++;
        if (pat != exp_pat) begin
            errors++;
            $display("FAIL grant_pattern got=%s want=%s", pat, exp_pat);
        end
        i_req = 1'b0; d_req = 1'b0;
        for (int j = 0; j < 4; j++) tick();

        // Interleaved reads on the latency-3 arbiter
        preset(0, 32'hA0000000);
        preset(1, 32'hB0000004);
        preset(2, 32'hC0000008);
        i_req = 1'b1; i_addr = 32'h0;
        tick();
        i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4;
        tick();
        d_req = 1'b0; i_req = 1'b1; i_addr = 32'h8;
        tick();
        i_req = 1'b0;
        tick();
        chk("il_r0_iv", 1, {31'h0, s_iv[1]}, 32'h1);
        chk("il_r0_data", 1, s_ir[1], 32'hA0000000);
        chk("il_r0_dv", 1, {31'h0, s_dv[1]}, 32'h0);
        tick();
        chk("il_r1_dv", 1, {31'h0, s_dv[1]}, 32'h1);
        chk("il_r1_data", 1, s_dr[1], 32'hB0000004);
        tick();
        chk("il_r2_iv", 1, {31'h0, s_iv[1]}, 32'h1);
        chk("il_r2_data", 1, s_ir[1], 32'hC0000008);
        for (int j = 0; j < 3; j++) tick();

        // Reset pulse while a read is outstanding on both arbiters
        i_req = 1'b1; i_addr = 32'h10;
        tick();
        chk("rst_issue", 1, {31'h0, s_ig[1]}, 32'h1);
        i_req = 1'b0; reset = 1'b1;
        tick();
        chk("rst_lat1_drop", 0, {31'h0, s_iv[0]}, 32'h0);
        reset = 1'b0;
        seen = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            seen = seen | s_iv[1] | s_iv[0];
        end
        chk("rst_lat3_drop", 1, {31'h0, seen}, 32'h0);

        // Randomised traffic with occasional resets
        for (int j = 0; j < 2000; j++) begin
            if (!i_req || g_i) begin
                i_req  = ($urandom_range(0, 99) < 60);
                i_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!d_req || g_d) begin
                d_req   = ($urandom_range(0, 99) < 60);
                d_we    = ($urandom_range(0, 99) < 40);
                d_addr  = 32'($urandom_range(0, 15)) << 2;
                d_wdata = $urandom;
            end
            reset = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
        for (int j = 0; j < 4; j++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates a single-port, pipelined unified memory between the CPU instruction-fetch port and the CPU data port, so both can share one memory macro. Each cycle it grants at most one request and drives the memory. It tags every read and routes the returned data back to the requester after the fixed memory read latency. It sits between the CPU and the memory, in place of separate instruction and data memories.

Parameters:
ADDR_W, 32, address width of both ports and the memory
DATA_W, 32, data width
RD_LAT, 1, memory read latency in cycles (>=1); mem_rdata is valid RD_LAT cycles after a read is issued
MAX_WAIT, 4, maximum number of consecutive cycles the fetch port may be refused (fixed-priority mode only)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous reset, active-high
i_req  in  1  fetch read request
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch request accepted this cycle
i_rvalid  out  1  fetch read data valid
i_rdata  out  DATA_W  fetch read data
d_req  in  1  data request
d_we  in  1  data write (1) / read (0)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  data write data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  data read data valid (reads only)
d_rdata  out  DATA_W  data read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, RD_LAT cycles after issue

Behaviour:
- Handshake: a transfer occurs in the cycle where req and gnt are both high. The requester holds req, addr and wdata stable until gnt. The arbiter never withdraws a grant and never grants an idle port.
- gnt is combinational from the current req inputs and registered state. At most one gnt is high per cycle. In the grant cycle, mem_en=1 and mem_we/addr/wdata are driven from the winner.
- With no grant: mem_en=0, mem_we=0, mem_addr and mem_wdata = 0.
- Fixed priority (default): the data port wins ties, except when wait_cnt==MAX_WAIT, in which case fetch wins.
- wait_cnt: increments (saturating at MAX_WAIT) on each cycle with i_req & ~i_gnt; clears on any cycle with i_gnt.
- Read return: each granted read pushes {valid, port} into an RD_LAT-deep tag shift register. RD_LAT cycles later the matching x_rvalid pulses for 1 cycle and x_rdata = mem_rdata.
- Writes push valid=0 and produce no rvalid.
- x_rdata = 0 whenever x_rvalid = 0.
- Back-to-back reads, one per cycle, are fully pipelined. Fetch and data returns may interleave in any order and are always delivered in issue order.
- Reset values: i_gnt, d_gnt, i_rvalid, d_rvalid and mem_en are 0; the tag pipe is cleared; wait_cnt=0; last_winner=data.
- Reset mid-operation: in-flight reads are discarded and no rvalid is produced for them. mem_rdata arriving after reset is ignored.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. On a tie, the port that is not last_winner wins. last_winner updates on every grant. wait_cnt and MAX_WAIT are unused, and wait_cnt is held at 0.
- Undefined: fixed data priority with the MAX_WAIT anti-starvation rule above.

Decomposition:
- Package mem_arb_pkg holds:
  - port id constants PORT_I=1'b0 and PORT_D=1'b1
  - the read-tag struct {valid, port}
  - default ADDR_W and DATA_W constants
- Sub-module rd_tag_pipe: the RD_LAT-stage shift register with async clear, outputting the tag aligned with mem_rdata.

Test Plan:
- Reset, then idle: all gnt, rvalid and mem_en are 0. A reset pulse asserted during an outstanding read suppresses its rvalid.
- Fetch-only read at 0x10 with memory returning 0xDEADBEEF (RD_LAT=1): i_gnt in cycle N; i_rvalid=1 and i_rdata=0xDEADBEEF in cycle N+1; d_rvalid stays 0.
- Data write of 0x12345678 to 0x40: d_gnt with mem_we=1, mem_addr=0x40, mem_wdata=0x12345678. No d_rvalid follows. A subsequent data read of 0x40 returns 0x12345678.
- Both ports requesting every cycle, fixed priority, MAX_WAIT=4: the data port wins 4 cycles, then fetch wins in the 5th; the pattern repeats. Fetch is never refused more than 4 consecutive cycles.
- Same stimulus with MEM_ARB_RR_EN defined: grants alternate I, D, I, D…, starting with fetch after reset.
- RD_LAT=3 with an interleaved read sequence I(0x0), D(0x4), I(0x8): the returns arrive in the same order, 3 cycles after each issue, each on the correct port with the correct data.
